// File: rtl/icache_sram.sv
// Storage array of the L1 I-cache: 2-way set-associative tag/valid/data with
// per-set LRU. Lookups are combinational; block fills happen on the clock edge.
module icache_sram #(
  parameter int ITAG_SIZE        = 21,
  parameter int ISET_INDEX_SIZE  = 6,
  parameter int IBLOCK_SIZE_BITS = 256
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 ren,
  input  logic                                 memWen,
  input  logic [ITAG_SIZE+ISET_INDEX_SIZE-1:0] blockAddr,
  input  logic [IBLOCK_SIZE_BITS-1:0]          dataIn,
  output logic                                 hit,
  output logic [IBLOCK_SIZE_BITS-1:0]          dataOut
);

  localparam int ADDR_W   = ITAG_SIZE + ISET_INDEX_SIZE;
  localparam int NUM_SETS = 1 << ISET_INDEX_SIZE;
  localparam int NUM_WAYS = 2;

  logic [ITAG_SIZE-1:0]        addr_tag;
  logic [ISET_INDEX_SIZE-1:0]  set_idx;

  // Valid bits per way, LRU bit per set (names the way to evict next).
  logic [NUM_SETS-1:0]         valid_reg [NUM_WAYS];
  logic [NUM_SETS-1:0]         lru_reg;

  logic [ITAG_SIZE-1:0]        way_tag   [NUM_WAYS];
  logic [IBLOCK_SIZE_BITS-1:0] way_data  [NUM_WAYS];
  logic [NUM_WAYS-1:0]         way_valid;
  logic [NUM_WAYS-1:0]         way_match;
  logic [NUM_WAYS-1:0]         way_write;

  logic                        any_match;
  logic                        match_way;
  logic                        fill_way;
  logic                        fill_en;
  logic                        lookup_hit;

  assign addr_tag = blockAddr[ADDR_W-1:ISET_INDEX_SIZE];
  assign set_idx  = blockAddr[ISET_INDEX_SIZE-1:0];
  assign fill_en  = memWen && !rst;

  // Tag and data storage per way; never reset, only valid bits qualify them.
  generate
    for (genvar gi = 0; gi < NUM_WAYS; gi++) begin : gen_way
      logic [ITAG_SIZE-1:0]        tag_mem  [NUM_SETS];
      logic [IBLOCK_SIZE_BITS-1:0] data_mem [NUM_SETS];

      assign way_write[gi] = fill_en && (fill_way == gi[0]);

      always_ff @(posedge clk) begin
        if (way_write[gi]) begin
          tag_mem[set_idx]  <= addr_tag;
          data_mem[set_idx] <= dataIn;
        end
      end

      assign way_tag[gi]   = tag_mem[set_idx];
      assign way_data[gi]  = data_mem[set_idx];
      assign way_valid[gi] = valid_reg[gi][set_idx];
      assign way_match[gi] = way_valid[gi] && (way_tag[gi] == addr_tag);
    end
  endgenerate

  assign any_match = |way_match;
  // Fills never duplicate a tag within a set, so at most one way matches.
  assign match_way = way_match[1];

  always_comb begin
    fill_way = lru_reg[set_idx];
    if (any_match) begin
      fill_way = match_way;
    end else if (!way_valid[0]) begin
      fill_way = 1'b0;
    end else if (!way_valid[1]) begin
      fill_way = 1'b1;
    end
  end

  assign lookup_hit = ren && !rst && any_match;

  always_comb begin
    hit     = lookup_hit;
    dataOut = '0;
    if (lookup_hit) begin
      dataOut = way_data[match_way];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int w = 0; w < NUM_WAYS; w++) begin
        valid_reg[w] <= '0;
      end
      lru_reg <= '0;
    end else if (memWen) begin
      valid_reg[fill_way][set_idx] <= 1'b1;
      lru_reg[set_idx]             <= ~fill_way;
    end else if (lookup_hit) begin
      lru_reg[set_idx] <= ~match_way;
    end
  end

endmodule

// File: tb/tb_icache_sram.sv
// Directed bench for icache_sram: fills, lookups, LRU eviction, reset behaviour.
module tb_icache_sram;

  localparam int TW = 21;
  localparam int SW = 6;
  localparam int BW = 256;

  logic          clk = 1'b0;
  logic          rst;
  logic          ren;
  logic          memWen;
  logic [TW+SW-1:0] blockAddr;
  logic [BW-1:0] dataIn;
  logic          hit;
  logic [BW-1:0] dataOut;

  int tests = 0;
  int fails = 0;

  logic [BW-1:0] ones;
  logic [BW-1:0] d1;
  logic [BW-1:0] d2;
  logic [TW-1:0] tag_ones;

  icache_sram #(
    .ITAG_SIZE(TW), .ISET_INDEX_SIZE(SW), .IBLOCK_SIZE_BITS(BW)
  ) dut (
    .clk(clk), .rst(rst), .ren(ren), .memWen(memWen),
    .blockAddr(blockAddr), .dataIn(dataIn), .hit(hit), .dataOut(dataOut)
  );

  always #5 clk = ~clk;

  function automatic logic [TW+SW-1:0] mk(input logic [TW-1:0] t, input logic [SW-1:0] s);
    return {t, s};
  endfunction

  task automatic check(input string name, input logic [BW-1:0] obs, input logic [BW-1:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", name, obs, exp);
    end
  endtask

  // Called at a negedge: drive a fill across the next rising edge.
  task automatic fill(input logic [TW+SW-1:0] a, input logic [BW-1:0] d);
    memWen    = 1'b1;
    ren       = 1'b0;
    blockAddr = a;
    dataIn    = d;
    @(negedge clk);
    memWen = 1'b0;
  endtask

  // Called at a negedge: lookup held through the next rising edge.
  task automatic rd(input string name, input logic [TW+SW-1:0] a,
                    input logic exp_hit, input logic [BW-1:0] exp_data);
    ren       = 1'b1;
    blockAddr = a;
    #1;
    check({name, "_hit"}, {{(BW-1){1'b0}}, hit}, {{(BW-1){1'b0}}, exp_hit});
    check({name, "_data"}, dataOut, exp_data);
    $display("[TB] read %s addr=%h hit=%0b", name, a, hit);
    @(negedge clk);
    ren = 1'b0;
  endtask

  initial begin
    ones     = '1;
    d1       = {32'hFFFFFFFF, 224'h0};
    d2       = {32'h0, {224{1'b1}}};
    tag_ones = '1;
    rst = 1'b1; ren = 1'b1; memWen = 1'b0; blockAddr = '0; dataIn = '0;

    // Reset: outputs forced low even while reading
    @(negedge clk);
    @(negedge clk);
    #1;
    check("rst_hit", {{(BW-1){1'b0}}, hit}, '0);
    check("rst_data", dataOut, '0);
    rst = 1'b0;
    @(negedge clk);
    rd("post_rst", mk(0, 0), 1'b0, '0);

    // Two tags into set 0
    fill(mk(0, 0), '0);
    fill(mk(tag_ones, 0), ones);
    rd("s0_t0", mk(0, 0), 1'b1, '0);
    rd("s0_t1", mk(tag_ones, 0), 1'b1, ones);

    // Refill an existing tag twice: overwrite in place, no eviction
    fill(mk(tag_ones, 0), d1);
    fill(mk(tag_ones, 0), d2);
    rd("refill_t1", mk(tag_ones, 0), 1'b1, d2);
    rd("refill_t0", mk(0, 0), 1'b1, '0);

    // Idle: ren low on a resident block
    ren = 1'b0; blockAddr = mk(0, 0); #1;
    check("idle_hit", {{(BW-1){1'b0}}, hit}, '0);
    check("idle_data", dataOut, '0);
    @(negedge clk);

    // LRU: reading tag 0 makes way 1 (tag A) the victim for tag B
    rd("lru_t0", mk(0, 0), 1'b1, '0);
    fill(mk(21'h5, 0), 256'h5);
    rd("lru_A_gone", mk(tag_ones, 0), 1'b0, '0);
    rd("lru_t0_kept", mk(0, 0), 1'b1, '0);
    rd("lru_B", mk(21'h5, 0), 1'b1, 256'h5);

    // Same-cycle read+fill on empty set 3
    ren = 1'b1; memWen = 1'b1; blockAddr = mk(21'h7, 3); dataIn = 256'hABCD; #1;
    check("rw_same_hit", {{(BW-1){1'b0}}, hit}, '0);
    check("rw_same_data", dataOut, '0);
    @(negedge clk);
    memWen = 1'b0; #1;
    check("rw_next_hit", {{(BW-1){1'b0}}, hit}, {{(BW-1){1'b0}}, 1'b1});
    check("rw_next_data", dataOut, 256'hABCD);
    @(negedge clk);
    ren = 1'b0;

    // Read-hit during a fill must not touch LRU: t3 evicts t1 (LRU=way 0)
    fill(mk(21'h1, 9), 256'h11);
    fill(mk(21'h2, 9), 256'h22);
    ren = 1'b1; memWen = 1'b1; blockAddr = mk(21'h2, 9); dataIn = 256'h33; #1;
    check("rw_hit_pre", {{(BW-1){1'b0}}, hit}, {{(BW-1){1'b0}}, 1'b1});
    check("rw_hit_pre_data", dataOut, 256'h22);
    blockAddr = mk(21'h3, 9); #1;
    @(negedge clk);
    memWen = 1'b0; ren = 1'b0;
    rd("s9_t1_gone", mk(21'h1, 9), 1'b0, '0);
    rd("s9_t2", mk(21'h2, 9), 1'b1, 256'h22);
    rd("s9_t3", mk(21'h3, 9), 1'b1, 256'h33);

    // Back-to-back fills across sets
    fill(mk(21'h4, 4), 256'h44);
    fill(mk(21'h5, 5), 256'h55);
    fill(mk(21'h6, 6), 256'h66);
    rd("b2b_s4", mk(21'h4, 4), 1'b1, 256'h44);
    rd("b2b_s5", mk(21'h5, 5), 1'b1, 256'h55);
    rd("b2b_s6", mk(21'h6, 6), 1'b1, 256'h66);

    // One-cycle reset with a fill attempt that must be ignored
    rst = 1'b1;
    fill(mk(21'h7, 7), 256'h77);
    rst = 1'b0;
    rd("rst_s0", mk(0, 0), 1'b0, '0);
    rd("rst_s3", mk(21'h7, 3), 1'b0, '0);
    rd("rst_s4", mk(21'h4, 4), 1'b0, '0);
    rd("rst_s6", mk(21'h6, 6), 1'b0, '0);
    rd("rst_s7_ign", mk(21'h7, 7), 1'b0, '0);

    // After reset, first fill goes to way 0 and second to way 1, both resident
    fill(mk(21'h8, 2), 256'h88);
    fill(mk(21'h9, 2), 256'h99);
    rd("post_s2_a", mk(21'h8, 2), 1'b1, 256'h88);
    rd("post_s2_b", mk(21'h9, 2), 1'b1, 256'h99);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/icache_sram.md
# icache_sram

Storage array of the L1 instruction cache: a 2-way set-associative tag/valid/data SRAM with per-set LRU replacement. It sits between the I-cache controller and the fetch datapath. The controller presents a block address (tag + set index) and either performs a combinational read lookup (`ren`) or fills a whole block returned from memory (`memWen`). It contains no FSM; miss handling belongs to the controller.

## Interface
Parameters (taken from `constants.vh` macros):
- `ITAG_SIZE`, default 21: tag width in bits.
- `ISET_INDEX_SIZE`, default 6: set index width (64 sets).
- `IBLOCK_SIZE_BITS`, default 256: block width (8 × 32-bit words).
- Associativity is fixed at 2 ways.

Ports:
- `clk` input 1: single clock; all state updates on the rising edge.
- `rst` input 1: reset, synchronous and active-high.
- `ren` input 1: read/lookup enable.
- `memWen` input 1: block fill enable (write from memory).
- `blockAddr` input `ITAG_SIZE+ISET_INDEX_SIZE`: block address. Tag is `[MSB:ISET_INDEX_SIZE]`; set index is `[ISET_INDEX_SIZE-1:0]`.
- `dataIn` input `IBLOCK_SIZE_BITS`: fill data.
- `hit` output 1: lookup hit.
- `dataOut` output `IBLOCK_SIZE_BITS`: block data of the hitting way.

## Operation
State per set:
- 2 × {valid, tag, data}.
- 1 LRU bit, which names the way to evict next.

Read (`ren=1`, combinational):
- Compare the tag against both ways of the indexed set.
- `hit=1` iff some way is valid and its tag matches. `dataOut` = that way's data.
- On a miss, `hit=0` and `dataOut=0`.
- Only one way can match, because fills never duplicate a tag within a set.

Idle (`ren=0`):
- `hit=0`, `dataOut=0`.

Fill (`memWen=1`, at the rising edge). Way selection:
- If a valid way in the set already holds the tag, overwrite that way (no duplicate, no eviction).
- Otherwise, if an invalid way exists, use the lowest-numbered invalid way.
- Otherwise, use the way named by LRU.

Fill effects:
- Set the chosen way's valid=1, tag=addr tag, data=`dataIn`.
- Set LRU to the other way.

LRU update on read:
- If `ren=1`, `hit=1` and `memWen=0`, at the edge set LRU to the way not hit.

Other rules:
- `memWen` and `ren` both high: perform the fill. `hit`/`dataOut` in that cycle reflect pre-edge contents. The read does not update LRU.
- Reset:
  - Clears all valid bits and LRU bits (LRU=way 0).
  - Tag and data arrays are not cleared.
  - While `rst=1`, `hit=0` and `dataOut=0`, and fills are ignored.

## Timing
- Read latency 0 cycles: `hit`/`dataOut` are valid combinationally in the same cycle as `ren`/`blockAddr`.
- Fill latency 1 edge: data written at edge N is readable (hit) in the cycle after edge N.
- Consecutive fills on back-to-back cycles are supported, one per cycle.
- Reset asserted mid-operation takes effect at the next edge. The following cycle reads all miss.
- Outputs after reset: `hit=0`, `dataOut=0`.

## Test plan
- Reset, then `ren=1` with `blockAddr=0` -> `hit=0`, `dataOut=0`.
- Fill set 0, tag 0, data all-zeros. Then fill set 0, tag all-ones, data all-ones. Read both addresses -> both hit, returning all-zeros and all-ones respectively (ways 0 and 1 used).
- Fill set 0, tag all-ones twice in succession, data `{32'hFFFFFFFF,224'h0}` then `{32'h0,224'h…FFFF}`. Read tag all-ones -> hit, `dataOut={32'h0, all-ones}`. Tag 0 still hits (no eviction).
- With both ways of set 0 full (tag 0 in way 0, tag A in way 1), read tag 0 (LRU→way 1). Fill tag B -> tag A misses, tag 0 and tag B hit.
- Same cycle `ren=1` and `memWen=1` on an empty set -> `hit=0` that cycle, `hit=1` the next cycle.
- After filling several sets, assert `rst` for 1 cycle -> every read misses afterward.
